dcache_sa: RTL and testbench
============================

Name: dcache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache.
- Sits between the pipeline MEM stage (p1_* port) and the 256-bit line data memory (mem_* port).
- Generalises the direct-mapped dcache in ways and sets, and adds true-LRU replacement and hit/miss counters.
- Stalls the pipeline via p1_stall_o while a miss is serviced.

Parameters:
WAYS, 2, associativity; power of 2, range 1..8
SETS, 16, sets per way; power of 2, at least 2
LINE_W, 256, line width in bits; fixed at 8 words
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
p1_addr_i  in  ADDR_W  byte address of the CPU request (word aligned)
p1_data_i  in  32  CPU store data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  32  load data
p1_stall_o  out  1  pipeline stall
mem_data_i  in  LINE_W  refill line from memory
mem_ack_i  in  1  memory transaction complete
mem_data_o  out  LINE_W  writeback line to memory
mem_addr_o  out  ADDR_W  line address to memory; low 5 bits are 0
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1 = writeback, 0 = refill
hit_cnt_o  out  32  count of hit requests (wraps)
miss_cnt_o  out  32  count of miss requests (wraps)

Behaviour:
- Address split:
  - word offset = addr[4:2]
  - index = addr[4+log2(SETS):5]
  - tag = remaining upper bits
- Per line storage: valid, dirty, tag, data, log2(WAYS)-bit age.
- Reset (async):
  - All valid, dirty and age bits clear; state IDLE.
  - Every output is 0, including both counters.
  - An in-flight memory transaction is abandoned; a late mem_ack_i is ignored in IDLE.
- Request = MemRead | MemWrite. Both asserted at once: treat as a write. p1_data_o is then don't-care.
- Hit = valid && tag match in some way; at most one way matches.
- IDLE, hit:
  - p1_stall_o = 0.
  - Load: p1_data_o = selected word, combinational in the same cycle.
  - Store: the word is written at the clock edge and dirty is set.
  - LRU update at the edge: accessed way age := 0; ways younger than its old age increment.
  - hit_cnt_o increments, except in the replay cycle after REFILL.
- IDLE, miss:
  - p1_stall_o = 1 combinationally; miss_cnt_o increments once.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - Next state is WRITEBACK if the victim is valid && dirty, else REFILL.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - All are held stable until the mem_ack_i cycle, then REFILL.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}.
  - On mem_ack_i: line := mem_data_i, tag written, valid = 1, dirty = 0; go to REPLAY.
- REPLAY:
  - mem_enable_o = 0, p1_stall_o = 1; next state is IDLE.
  - The next cycle re-looks-up the request, which now hits and is served as a normal hit, not counted.
- Stall and request rules:
  - p1_stall_o = 1 throughout WRITEBACK, REFILL and REPLAY.
  - The CPU holds p1_* stable while stalled.
  - mem_enable_o drops the cycle after ack.
  - mem_ack_i outside WRITEBACK or REFILL is ignored.
  - No request in IDLE: no state change, no counter change.
- Memory latency is unbounded; the controller waits indefinitely.
- WAYS = 1 degenerates to a direct-mapped cache with no age storage; the victim is always way 0.

Test Plan:
1. Cold load 0x0000_0120 after reset, ack after 5 cycles:
   - mem_enable_o=1, mem_write_o=0, mem_addr_o=0x120; stall for 7 cycles.
   - p1_data_o = word 0 of the line; miss_cnt_o=1, hit_cnt_o=0.
2. Store 0xDEADBEEF to 0x124 after test 1:
   - No stall; hit_cnt_o=1.
   - A following load of 0x124 returns 0xDEADBEEF with no stall; hit_cnt_o=2.
3. Dirty eviction, continuing from test 2 (WAYS=2, SETS=16):
   - Load 0x320 fills way 1.
   - Load 0x520 evicts LRU way 0 (dirty): writeback with mem_addr_o=0x120 and the line containing 0xDEADBEEF, then refill of 0x520.
4. LRU ordering:
   - Load 0x120, 0x320, then 0x120 again; then load 0x520.
   - The victim is the 0x320 way, evicted with no writeback since it is clean.
5. Simultaneous MemRead and MemWrite to a hit address: the store occurs and the counter increments by 1.
6. rst_i pulsed in the middle of WRITEBACK:
   - mem_enable_o=0 and p1_stall_o=0 immediately; counters are 0.
   - A later ack is ignored; load 0x124 misses.

Source files
------------

// File: rtl/dcache_sa.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement
// and hit/miss counters, between the MEM stage and a 256-bit line memory.
module dcache_sa #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDR_W - 5 - IdxW;
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StReplay} state_e;

  state_e              state_q, state_d;
  logic                replay_q, replay_d;
  logic [WayW-1:0]     victim_q, victim_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic                valid_q [WAYS][SETS];
  logic                dirty_q [WAYS][SETS];
  logic [WayW-1:0]     age_q   [WAYS][SETS];
  logic [TagW-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]   data_q  [WAYS][SETS];

  logic [IdxW-1:0]     idx;
  logic [TagW-1:0]     req_tag;
  logic [2:0]          word;
  logic                req;
  logic                hit;
  logic [WayW-1:0]     hit_way;
  logic                inv_found;
  logic [WayW-1:0]     inv_way;
  logic [WayW-1:0]     old_way;
  logic [WayW-1:0]     miss_victim;
  logic [LINE_W-1:0]   hit_line;
  logic                store_en;
  logic                refill_en;
  logic                lru_en;
  logic                unused_addr_bits;

  assign idx              = p1_addr_i[5 +: IdxW];
  assign req_tag          = p1_addr_i[ADDR_W-1 -: TagW];
  assign word             = p1_addr_i[4:2];
  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign unused_addr_bits = ^p1_addr_i[1:0];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
      if (age_q[w][idx] == WayW'(WAYS - 1)) begin
        old_way = WayW'(w);
      end
    end
    miss_victim = inv_found ? inv_way : old_way;
  end

  assign hit_line   = data_q[hit_way][idx];
  assign p1_data_o  = (!rst_i && (state_q == StIdle) && req && hit) ?
                      hit_line[{word, 5'b0} +: 32] : 32'h0;
  assign p1_stall_o = !rst_i && ((state_q != StIdle) || (req && !hit));

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    replay_d     = replay_q;
    victim_d     = victim_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    store_en     = 1'b0;
    refill_en    = 1'b0;
    lru_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        replay_d = 1'b0;
        if (req && hit) begin
          lru_en   = 1'b1;
          store_en = p1_MemWrite_i;
          if (!replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (req) begin
          miss_cnt_d   = miss_cnt_q + 32'd1;
          victim_d     = miss_victim;
          mem_enable_d = 1'b1;
          if (valid_q[miss_victim][idx] && dirty_q[miss_victim][idx]) begin
            state_d     = StWriteback;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[miss_victim][idx], idx, 5'b0};
            mem_data_d  = data_q[miss_victim][idx];
          end else begin
            state_d     = StRefill;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, idx, 5'b0};
          end
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          state_d     = StRefill;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, idx, 5'b0};
          mem_data_d  = '0;
        end
      end
      StRefill: begin
        if (mem_ack_i) begin
          refill_en    = 1'b1;
          state_d      = StReplay;
          mem_enable_d = 1'b0;
          mem_addr_d   = '0;
        end
      end
      StReplay: begin
        state_d  = StIdle;
        replay_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      replay_q     <= 1'b0;
      victim_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      replay_q     <= replay_d;
      victim_q     <= victim_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Ways at or below the accessed way's age age by one, so untouched ways stay oldest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= '0;
        end
      end
    end else begin
      if (store_en) dirty_q[hit_way][idx] <= 1'b1;
      if (refill_en) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (lru_en) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (WayW'(w) == hit_way) begin
            age_q[w][idx] <= '0;
          end else if (age_q[w][idx] <= age_q[hit_way][idx]) begin
            age_q[w][idx] <= age_q[w][idx] + WayW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_en) data_q[hit_way][idx][{word, 5'b0} +: 32] <= p1_data_i;
    if (refill_en) begin
      data_q[victim_q][idx] <= mem_data_i;
      tag_q[victim_q][idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_sa.sv
// Directed bench for dcache_sa: a line-level cache model with recency lists and a backing
// memory predicts every stall, memory handshake, load value and counter.
module tb_dcache_sa;
  localparam int WAYS = 2;
  localparam int SETS = 16;
  localparam int TAGW = 32 - 5 - $clog2(SETS);

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic         p1_rd;
  logic         p1_wr;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_en;
  logic         mem_we;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  always #5 clk = ~clk;

  dcache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .p1_addr_i    (p1_addr),
    .p1_data_i    (p1_wdata),
    .p1_MemRead_i (p1_rd),
    .p1_MemWrite_i(p1_wr),
    .p1_data_o    (p1_rdata),
    .p1_stall_o   (p1_stall),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .mem_data_o   (mem_wdata),
    .mem_addr_o   (mem_addr),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_we),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state
  bit            m_valid [WAYS][SETS];
  bit            m_dirty [WAYS][SETS];
  logic [TAGW-1:0] m_tag [WAYS][SETS];
  logic [255:0]  m_line  [WAYS][SETS];
  int            order   [SETS][$];
  logic [255:0]  bmem    [int unsigned];
  logic [31:0]   exp_hit = 0;
  logic [31:0]   exp_miss = 0;
  bit            cnt_chk = 0;

  // Observations for literal checks
  logic [31:0]   last_data;
  int            last_stalls;
  bit            last_hit;
  int            wb_seen = 0;
  logic [31:0]   obs_wb_addr;
  logic [255:0]  obs_wb_line;

  function automatic logic [255:0] pattern(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC0DE0000 | ((la + 32'(4 * i)) & 32'hFFFF);
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    if (bmem.exists(la)) return bmem[la];
    return pattern(la);
  endfunction

  task automatic touch(input int s, input int w);
    for (int i = 0; i < order[s].size(); i++) begin
      if (order[s][i] == w) begin
        order[s].delete(i);
        break;
      end
    end
    order[s].push_front(w);
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++) begin
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    end
    for (int s = 0; s < SETS; s++) order[s].delete();
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counters are compared on every falling edge while the model tracks them.
  always @(negedge clk) begin
    if (cnt_chk) begin
      check("hit_cnt", hit_cnt, exp_hit);
      check("miss_cnt", miss_cnt, exp_miss);
    end
    if (mem_en && mem_we) begin
      wb_seen++;
      obs_wb_addr = mem_addr;
      obs_wb_line = mem_wdata;
    end
  end

  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input int lat);
    int s, w, v, stalls;
    logic [TAGW-1:0] t;
    logic [31:0] la, wba;
    bit hit;
    s  = int'(a[8:5]);
    t  = a[31:9];
    la = {a[31:5], 5'b0};
    hit = 0;
    w = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (m_valid[i][s] && m_tag[i][s] == t) begin
        hit = 1;
        w = i;
      end
    end
    p1_addr = a; p1_rd = rd; p1_wr = wr; p1_wdata = wd;
    stalls = 0;
    last_hit = hit;
    if (!hit) begin
      v = -1;
      for (int i = 0; i < WAYS; i++) if (!m_valid[i][s] && v < 0) v = i;
      if (v < 0) v = order[s][$];
      @(negedge clk);
      check("miss_stall", p1_stall, 1'b1);
      check("miss_idle_en", mem_en, 1'b0);
      if (p1_stall) stalls++;
      step();
      exp_miss++;
      if (m_valid[v][s] && m_dirty[v][s]) begin
        wba = {m_tag[v][s], a[8:5], 5'b0};
        for (int c = 1; c <= lat; c++) begin
          mem_ack = (c == lat);
          @(negedge clk);
          check("wb_en", mem_en, 1'b1);
          check("wb_we", mem_we, 1'b1);
          check("wb_addr", mem_addr, wba);
          check("wb_data", mem_wdata, m_line[v][s]);
          check("wb_stall", p1_stall, 1'b1);
          if (p1_stall) stalls++;
          step();
        end
        mem_ack = 0;
        bmem[wba] = m_line[v][s];
      end
      for (int c = 1; c <= lat; c++) begin
        mem_ack = (c == lat);
        mem_rdata = get_line(la);
        @(negedge clk);
        check("rf_en", mem_en, 1'b1);
        check("rf_we", mem_we, 1'b0);
        check("rf_addr", mem_addr, la);
        check("rf_stall", p1_stall, 1'b1);
        if (p1_stall) stalls++;
        step();
      end
      mem_ack = 0;
      m_line[v][s]  = get_line(la);
      m_tag[v][s]   = t;
      m_valid[v][s] = 1;
      m_dirty[v][s] = 0;
      @(negedge clk);
      check("replay_stall", p1_stall, 1'b1);
      check("replay_en", mem_en, 1'b0);
      if (p1_stall) stalls++;
      step();
      w = v;
    end
    @(negedge clk);
    check("hit_stall", p1_stall, 1'b0);
    if (rd && !wr) check("load_data", p1_rdata, m_line[w][s][int'(a[4:2]) * 32 +: 32]);
    last_data = p1_rdata;
    step();
    if (wr) begin
      m_line[w][s][int'(a[4:2]) * 32 +: 32] = wd;
      m_dirty[w][s] = 1;
    end
    touch(s, w);
    if (hit) exp_hit++;
    p1_rd = 0; p1_wr = 0;
    last_stalls = stalls;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    bit seen;
    rst = 1'b1;
    p1_addr = 0; p1_wdata = 0; p1_rd = 0; p1_wr = 0;
    mem_rdata = 0; mem_ack = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_en", mem_en, 1'b0);
    check("rst_stall", p1_stall, 1'b0);
    check("rst_data", p1_rdata, 32'h0);
    check("rst_hit", hit_cnt, 32'h0);
    check("rst_miss", miss_cnt, 32'h0);
    step();
    cnt_chk = 1;

    // Cold load
    access(32'h120, 1, 0, 0, 5);
    check("t1_stalls", last_stalls, 7);
    check("t1_data", last_data, 32'hC0DE0120);
    check("t1_miss", miss_cnt, 1);
    check("t1_hit", hit_cnt, 0);

    // Store hit then load back
    access(32'h124, 0, 1, 32'hDEADBEEF, 3);
    check("t2_store_stalls", last_stalls, 0);
    check("t2_hit1", hit_cnt, 1);
    access(32'h124, 1, 0, 0, 3);
    check("t2_load", last_data, 32'hDEADBEEF);
    check("t2_hit2", hit_cnt, 2);

    // Dirty eviction of LRU way
    access(32'h320, 1, 0, 0, 2);
    snap = wb_seen;
    access(32'h520, 1, 0, 0, 3);
    check("t3_wb_happened", wb_seen > snap, 1'b1);
    check("t3_wb_addr", obs_wb_addr, 32'h120);
    check("t3_wb_word", obs_wb_line[63:32], 32'hDEADBEEF);

    // LRU ordering: the 0x320 line is the clean victim
    access(32'h120, 1, 0, 0, 2);
    access(32'h320, 1, 0, 0, 2);
    access(32'h120, 1, 0, 0, 2);
    check("t4_120_hit", last_stalls, 0);
    snap = wb_seen;
    access(32'h520, 1, 0, 0, 2);
    check("t4_no_wb", wb_seen - snap, 0);
    access(32'h120, 1, 0, 0, 2);
    check("t4_120_kept", last_stalls, 0);
    access(32'h320, 1, 0, 0, 2);
    check("t4_320_evicted", last_stalls != 0, 1'b1);

    // Read+write together acts as a store
    snap = int'(hit_cnt);
    access(32'h120, 1, 1, 32'h12345678, 2);
    check("t5_hit_inc", int'(hit_cnt) - snap, 1);
    access(32'h120, 1, 0, 0, 2);
    check("t5_load", last_data, 32'h12345678);

    // Make dirty 0x120 the LRU way, then reset during its writeback
    access(32'h320, 1, 0, 0, 2);
    cnt_chk = 0;
    p1_addr = 32'h720; p1_rd = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_en && mem_we) seen = 1;
      else step();
    end
    check("t6_wb_reached", seen, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p1_rd = 0;
    #1;
    check("t6_rst_en", mem_en, 1'b0);
    check("t6_rst_stall", p1_stall, 1'b0);
    check("t6_rst_hit", hit_cnt, 32'h0);
    check("t6_rst_miss", miss_cnt, 32'h0);
    step();
    rst = 1'b0;
    model_clear();
    cnt_chk = 1;
    mem_ack = 1;
    step();
    mem_ack = 0;
    @(negedge clk);
    check("t6_late_ack_en", mem_en, 1'b0);
    check("t6_late_ack_stall", p1_stall, 1'b0);
    step();
    access(32'h124, 1, 0, 0, 3);
    check("t6_miss_after_rst", last_hit, 1'b0);
    check("t6_data", last_data, 32'hDEADBEEF);
    check("t6_miss_cnt", miss_cnt, 1);
    check("t6_hit_cnt", hit_cnt, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
